// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and received-character status bundle
interface uart_rx_if;
  logic       serial_in;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_out;
  logic       parity_error;
  logic       frame_error;
  logic       rx_active;
  logic       rx_done;
  modport master (
    output serial_in, baud_rate, parity_type, stop_bits, data_length,
    input  data_out, parity_error, frame_error, rx_active, rx_done
  );
  modport slave (
    input  serial_in, baud_rate, parity_type, stop_bits, data_length,
    output data_out, parity_error, frame_error, rx_active, rx_done
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with configurable rate, length, parity and stop bits
module uart_rx #(
  parameter int BASE_DIV    = 2606,
  parameter int SYNC_STAGES = 2
) (
  input logic   clock,
  input logic   rst,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(BASE_DIV * 8 + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  logic w_rx, w_fall, w_tick, w_par_en, w_last_bit, w_active, w_done;
  logic [CW-1:0] r_cnt, w_period, w_period_in;
  logic [1:0] r_baud, r_par;
  logic r_sb, r_dl, r_stop_idx;
  logic [2:0] r_idx;
  logic [7:0] r_shift, r_data_out;
  logic r_par_err, r_frm_err, r_perr_out, r_ferr_out;
  assign w_rx        = r_sync[SYNC_STAGES-1];
  assign w_fall      = r_prev & ~w_rx;
  assign w_tick      = r_cnt == '0;
  assign w_period    = CW'(BASE_DIV) << (2'd3 - r_baud);
  assign w_period_in = CW'(BASE_DIV) << (2'd3 - bus.baud_rate);
  assign w_par_en    = ^r_par;
  assign w_last_bit  = r_idx == {2'b11, r_dl};
  assign bus.data_out     = r_data_out;
  assign bus.parity_error = r_perr_out;
  assign bus.frame_error  = r_ferr_out;
  assign bus.rx_active    = w_active;
  assign bus.rx_done      = w_done;
  // Synchronize the line and keep one delayed copy for falling-edge detection
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.serial_in};
      r_prev <= w_rx;
    end
  // State register
  always_ff @(posedge clock or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // Next-state logic and status outputs
  always_comb begin
    w_next   = r_state;
    w_active = (r_state != IDLE) && (r_state != DONE);
    w_done   = r_state == DONE;
    case (r_state)
      IDLE:    w_next = w_fall ? START : IDLE;
      START:   w_next = w_tick ? (w_rx ? IDLE : DATA) : START;
      DATA:    w_next = (w_tick && w_last_bit) ? (w_par_en ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_tick ? STOP : PARITY;
      STOP:    w_next = (w_tick && r_stop_idx == r_sb) ? DONE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // Bit timing, configuration latch, character assembly and result registers
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      r_cnt      <= '0;
      r_baud     <= '0;
      r_par      <= '0;
      r_sb       <= 1'b0;
      r_dl       <= 1'b0;
      r_stop_idx <= 1'b0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_data_out <= '0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_fall) begin
        r_cnt      <= (w_period_in >> 1) - CW'(1);
        r_baud     <= bus.baud_rate;
        r_par      <= bus.parity_type;
        r_sb       <= bus.stop_bits;
        r_dl       <= bus.data_length;
        r_stop_idx <= 1'b0;
        r_idx      <= '0;
        r_shift    <= '0;
        r_par_err  <= 1'b0;
        r_frm_err  <= 1'b0;
      end
    end else if (r_state != DONE) begin
      r_cnt <= w_tick ? w_period - CW'(1) : r_cnt - CW'(1);
      if (w_tick) begin
        if (r_state == DATA) begin
          r_shift[r_idx] <= w_rx;
          r_idx          <= r_idx + 3'd1;
        end
        if (r_state == PARITY) r_par_err <= ^r_shift ^ w_rx ^ r_par[0];
        if (r_state == STOP) begin
          r_frm_err  <= r_frm_err | ~w_rx;
          r_stop_idx <= 1'b1;
          if (w_next == DONE) begin
            r_data_out <= r_shift;
            r_perr_out <= r_par_err;
            r_ferr_out <= r_frm_err | ~w_rx;
          end
        end
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a frame-level reference model
module tb_uart_rx;
  localparam int BD = 16;
  localparam int SS = 2;
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, n_chk = 0, n_pass = 0, run = 0, max_run = 0;
  rec_t got_q[$], exp_q[$];
  logic [7:0] last_d = '0;
  logic last_pe = 1'b0, last_fe = 1'b0;
  uart_rx_if bus();
  uart_rx #(.BASE_DIV(BD), .SYNC_STAGES(SS)) dut (.clock(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.rx_done) got_q.push_back('{bus.data_out, bus.parity_error, bus.frame_error, cyc});
    run = bus.rx_done ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic dl, input logic [1:0] pt, input logic sb,
                            input logic [1:0] br, input logic flip, input logic [1:0] bad, input int gap);
    int p = BD << (3 - br);
    logic [7:0] dm = dl ? d : {1'b0, d[6:0]};
    logic pen = (pt == 2'b01) || (pt == 2'b10);
    logic bits[$];
    int t0;
    bits.push_back(1'b0);
    for (int i = 0; i < (dl ? 8 : 7); i++) bits.push_back(d[i]);
    if (pen) bits.push_back(^dm ^ (pt == 2'b01) ^ flip);
    bits.push_back(~bad[0]);
    if (sb) bits.push_back(~bad[1]);
    bus.baud_rate   = br;
    bus.parity_type = pt;
    bus.stop_bits   = sb;
    bus.data_length = dl;
    t0 = cyc;
    exp_q.push_back('{dm, pen & flip, bad[0] | (sb & bad[1]), t0 + SS + 1 + p / 2 + (bits.size() - 1) * p});
    foreach (bits[i]) begin
      bus.serial_in = bits[i];
      if (i == 1) begin
        check("active_in_frame", bus.rx_active, 1);
        bus.baud_rate   = 2'($urandom);
        bus.parity_type = 2'($urandom);
        bus.stop_bits   = 1'($urandom);
        bus.data_length = 1'($urandom);
      end
      repeat (p) @(negedge clk);
    end
    bus.serial_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask
  task automatic expect_frames();
    rec_t g, e;
    check("done_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("data_out", g.d, e.d);
      check("parity_error", g.pe, e.pe);
      check("frame_error", g.fe, e.fe);
      check("done_cycle", g.t, e.t);
      last_d  = e.d;
      last_pe = e.pe;
      last_fe = e.fe;
    end
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    bus.serial_in   = 1'b1;
    bus.baud_rate   = 2'b11;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    bus.data_length = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", bus.data_out, 0);
    check("rst_parity_error", bus.parity_error, 0);
    check("rst_frame_error", bus.frame_error, 0);
    check("rst_rx_active", bus.rx_active, 0);
    check("rst_rx_done", bus.rx_done, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 4);
    expect_frames();
    send_frame(8'h55, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 4);
    expect_frames();
    send_frame(8'h55, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 2'b00, 4);
    expect_frames();
    send_frame(8'h00, 1'b1, 2'b01, 1'b0, 2'b11, 1'b0, 2'b00, 4);
    expect_frames();
    send_frame(8'h00, 1'b1, 2'b01, 1'b0, 2'b11, 1'b0, 2'b01, BD);
    expect_frames();
    send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 0);
    send_frame(8'hC3, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 4);
    expect_frames();
    bus.baud_rate   = 2'b11;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    bus.data_length = 1'b1;
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.serial_in = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_active", bus.rx_active, 1);
    repeat (40) @(negedge clk);
    check("glitch_active_end", bus.rx_active, 0);
    check("glitch_no_done", got_q.size(), 0);
    check("glitch_data_out", bus.data_out, last_d);
    check("glitch_parity_error", bus.parity_error, last_pe);
    check("glitch_frame_error", bus.frame_error, last_fe);
    got_q.delete();
    fork
      send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 4);
      begin
        repeat (SS + 1 + BD / 2 + 4 * BD + 4) @(negedge clk);
        check("pre_rst_active", bus.rx_active, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data_out", bus.data_out, 0);
        check("mid_rst_parity_error", bus.parity_error, 0);
        check("mid_rst_frame_error", bus.frame_error, 0);
        check("mid_rst_rx_active", bus.rx_active, 0);
        check("mid_rst_rx_done", bus.rx_done, 0);
      end
    join
    exp_q.delete();
    check("rst_no_done", got_q.size(), 0);
    got_q.delete();
    @(negedge clk);
    rst = 1'b0;
    last_d = '0; last_pe = 1'b0; last_fe = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 4);
    expect_frames();
    bus.baud_rate   = 2'b11;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    bus.data_length = 1'b1;
    bus.serial_in = 1'b0;
    exp_q.push_back('{8'h00, 1'b0, 1'b1, cyc + SS + 1 + BD / 2 + 9 * BD});
    repeat (400) @(negedge clk);
    bus.serial_in = 1'b1;
    repeat (40) @(negedge clk);
    expect_frames();
    for (int n = 0; n < 16; n++) begin
      logic [1:0] br, pt, bad;
      logic sb;
      int p;
      br  = 2'($urandom);
      pt  = 2'($urandom);
      sb  = 1'($urandom);
      bad = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      p   = BD << (3 - br);
      send_frame(8'($urandom), 1'($urandom), pt, sb, br, 1'($urandom), bad,
                 (bad != 2'b00) ? p : int'($urandom_range(0, 8)));
      expect_frames();
    end
    check("done_width", max_run, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
